// File: rtl/afifo_rd_pkg.sv
// Shared constants and state encoding for the async-FIFO read-side traffic engine.
package afifo_rd_pkg;

   localparam int DATA_WIDTH      = 8;
   localparam int ADDR_WIDTH      = 4;
   localparam int MAX_EMPTY_RETRY = 10;
   localparam int RST_CYCLES      = 4;

   typedef enum logic [1:0] {
      RST_HOLD,
      IDLE,
      READ,
      UNDERFLOW
   } rd_state_t;

endpackage

// File: rtl/afifo_rd_out_reg.sv
// Single-entry holding register for captured FIFO words on a valid/ready stream.
module afifo_rd_out_reg #(
   parameter int DATA_WIDTH = afifo_rd_pkg::DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  slot_free
);
   import afifo_rd_pkg::*;

   assign slot_free = !out_valid || out_ready;

   // A load in the same cycle as a downstream accept replaces the word rather than clearing valid.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (clr) begin
         out_valid <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/afifo_rd_master.sv
// Read-domain traffic engine: executes burst/underflow commands against the FIFO read port
// and sequences the FIFO read-domain reset.
module afifo_rd_master #(
   parameter int DATA_WIDTH      = afifo_rd_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH      = afifo_rd_pkg::ADDR_WIDTH,
   parameter int MAX_EMPTY_RETRY = afifo_rd_pkg::MAX_EMPTY_RETRY,
   parameter int RST_CYCLES      = afifo_rd_pkg::RST_CYCLES,
   parameter int CNT_WIDTH       = ADDR_WIDTH + 1
) (
   input  logic                                 rclk,
   input  logic                                 rrst_n,
   input  logic                                 cmd_valid,
   output logic                                 cmd_ready,
   input  logic [CNT_WIDTH-1:0]                 cmd_len,
   input  logic                                 cmd_err_inject,
   input  logic                                 soft_rst_req,
   output logic                                 fifo_rrst_n,
   output logic                                 rinc,
   input  logic [DATA_WIDTH-1:0]                rdata,
   input  logic                                 rempty,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [DATA_WIDTH-1:0]                out_data,
   output logic [CNT_WIDTH-1:0]                 words_left,
   output logic [$clog2(MAX_EMPTY_RETRY+1)-1:0] retry_cnt,
   output logic                                 evt_empty_stall,
   output logic                                 evt_timeout,
   output logic                                 evt_underflow,
   output logic                                 evt_done,
   output logic                                 evt_rst_done
);
   import afifo_rd_pkg::*;

   localparam int RETRY_W = $clog2(MAX_EMPTY_RETRY + 1);
   localparam int HOLD_W  = $clog2(RST_CYCLES + 1);

   rd_state_t         state;
   logic [HOLD_W-1:0] hold_cnt;
   logic              slot_free;
   logic              capture;
   logic              empty_cyc;
   logic              cmd_fire;
   logic              soft_abort;

   always_comb begin
      soft_abort = soft_rst_req && (state != RST_HOLD);
      capture    = (state == READ) && !soft_rst_req && !rempty && slot_free;
      empty_cyc  = (state == READ) && !soft_rst_req && rempty;
      cmd_fire   = cmd_valid && cmd_ready;
   end

   // Commands are held off during the rst_done pulse so nothing lands inside the reset sequence.
   assign cmd_ready       = (state == IDLE) && !soft_rst_req && !evt_rst_done;
   assign evt_underflow   = (state == UNDERFLOW) && !soft_rst_req;
   assign rinc            = capture || evt_underflow;
   assign evt_empty_stall = empty_cyc;
   assign evt_timeout     = empty_cyc && (retry_cnt == RETRY_W'(MAX_EMPTY_RETRY - 1));

   afifo_rd_out_reg #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_reg (
      .clk       (rclk),
      .rst_n     (rrst_n),
      .clr       (soft_abort),
      .load      (capture),
      .load_data (rdata),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .slot_free (slot_free)
   );

   always_ff @(posedge rclk) begin
      if (!rrst_n) begin
         state        <= RST_HOLD;
         hold_cnt     <= '0;
         fifo_rrst_n  <= 1'b0;
         words_left   <= '0;
         retry_cnt    <= '0;
         evt_done     <= 1'b0;
         evt_rst_done <= 1'b0;
      end else begin
         evt_done     <= 1'b0;
         evt_rst_done <= 1'b0;
         if (soft_abort) begin
            state       <= RST_HOLD;
            hold_cnt    <= '0;
            fifo_rrst_n <= 1'b0;
            words_left  <= '0;
            retry_cnt   <= '0;
         end else begin
            case (state)
               RST_HOLD: begin
                  if (hold_cnt == HOLD_W'(RST_CYCLES - 1)) begin
                     fifo_rrst_n  <= 1'b1;
                     evt_rst_done <= 1'b1;
                     state        <= IDLE;
                  end else begin
                     hold_cnt <= hold_cnt + HOLD_W'(1);
                  end
               end
               IDLE: begin
                  if (cmd_fire) begin
                     if (cmd_err_inject) begin
                        state <= UNDERFLOW;
                     end else if (cmd_len == '0) begin
                        evt_done <= 1'b1;
                     end else begin
                        words_left <= cmd_len;
                        retry_cnt  <= '0;
                        state      <= READ;
                     end
                  end
               end
               READ: begin
                  if (capture) begin
                     retry_cnt <= '0;
                     if (words_left != '0) begin
                        words_left <= words_left - CNT_WIDTH'(1);
                     end
                     if (words_left == CNT_WIDTH'(1)) begin
                        evt_done <= 1'b1;
                        state    <= IDLE;
                     end
                  end else if (empty_cyc) begin
                     retry_cnt <= retry_cnt + RETRY_W'(1);
                     // Timeout abandons the rest of the burst without signalling completion.
                     if (evt_timeout) begin
                        words_left <= '0;
                        state      <= IDLE;
                     end
                  end
               end
               UNDERFLOW: begin
                  evt_done <= 1'b1;
                  state    <= IDLE;
               end
               default: state <= RST_HOLD;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_afifo_rd_master.sv
// Directed bench for afifo_rd_master: reset sequencing, bursts, stalls, timeout, underflow, soft reset.
module tb_afifo_rd_master;

   localparam int DW = 8;
   localparam int CW = 5;
   localparam int RW = 4;

   logic          rclk = 1'b0;
   logic          rrst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [CW-1:0] cmd_len;
   logic          cmd_err_inject;
   logic          soft_rst_req;
   logic          fifo_rrst_n;
   logic          rinc;
   logic [DW-1:0] rdata;
   logic          rempty;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [CW-1:0] words_left;
   logic [RW-1:0] retry_cnt;
   logic          evt_empty_stall;
   logic          evt_timeout;
   logic          evt_underflow;
   logic          evt_done;
   logic          evt_rst_done;

   int n_cmp = 0;
   int n_err = 0;
   int c_stall = 0, c_to = 0, c_rinc = 0, c_done = 0, c_uf = 0, c_rstd = 0;
   int s_stall, s_to, s_rinc, s_done, s_uf, s_rstd;

   afifo_rd_master dut (
      .rclk            (rclk),
      .rrst_n          (rrst_n),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_len         (cmd_len),
      .cmd_err_inject  (cmd_err_inject),
      .soft_rst_req    (soft_rst_req),
      .fifo_rrst_n     (fifo_rrst_n),
      .rinc            (rinc),
      .rdata           (rdata),
      .rempty          (rempty),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data),
      .words_left      (words_left),
      .retry_cnt       (retry_cnt),
      .evt_empty_stall (evt_empty_stall),
      .evt_timeout     (evt_timeout),
      .evt_underflow   (evt_underflow),
      .evt_done        (evt_done),
      .evt_rst_done    (evt_rst_done)
   );

   always #5 rclk = ~rclk;

   always @(negedge rclk) begin
      if (evt_empty_stall) c_stall++;
      if (evt_timeout)     c_to++;
      if (rinc)            c_rinc++;
      if (evt_done)        c_done++;
      if (evt_underflow)   c_uf++;
      if (evt_rst_done)    c_rstd++;
   end

   task automatic tick;
      @(posedge rclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic snap;
      s_stall = c_stall; s_to = c_to; s_rinc = c_rinc;
      s_done = c_done; s_uf = c_uf; s_rstd = c_rstd;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rrst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; cmd_err_inject = 1'b0;
      soft_rst_req = 1'b0; rempty = 1'b1; rdata = '0; out_ready = 1'b1;

      // Reset and release sequence
      tick; #1;
      chk("rst_fifo_rrst_n", fifo_rrst_n, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_words_left", words_left, 0);
      chk("rst_retry_cnt", retry_cnt, 0);
      chk("rst_rinc", rinc, 0);
      chk("rst_evts", {evt_empty_stall, evt_timeout, evt_underflow, evt_done, evt_rst_done}, 0);
      snap;
      tick; tick;
      rrst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick; #1;
         chk("t1_hold_low", fifo_rrst_n, 0);
         chk("t1_no_rst_done", evt_rst_done, 0);
      end
      tick; #1;
      chk("t1_release", fifo_rrst_n, 1);
      chk("t1_rst_done", evt_rst_done, 1);
      chk("t1_ready_blocked", cmd_ready, 0);
      tick; #1;
      chk("t1_rst_done_clear", evt_rst_done, 0);
      chk("t1_ready", cmd_ready, 1);
      chk("t1_rst_done_count", c_rstd - s_rstd, 1);

      // Three-word burst with data always present
      snap;
      cmd_valid = 1'b1; cmd_len = 5'd3; rempty = 1'b0; rdata = 8'hA1;
      #1;
      chk("t2_accept_ready", cmd_ready, 1);
      chk("t2_idle_rinc", rinc, 0);
      tick; cmd_valid = 1'b0; #1;
      chk("t2_wl3", words_left, 3);
      chk("t2_rinc1", rinc, 1);
      chk("t2_ov0", out_valid, 0);
      tick; rdata = 8'hA2; #1;
      chk("t2_ov1", out_valid, 1);
      chk("t2_d1", out_data, 8'hA1);
      chk("t2_wl2", words_left, 2);
      chk("t2_rinc2", rinc, 1);
      tick; rdata = 8'hA3; #1;
      chk("t2_d2", out_data, 8'hA2);
      chk("t2_wl1", words_left, 1);
      chk("t2_rinc3", rinc, 1);
      tick; rempty = 1'b1; #1;
      chk("t2_d3", out_data, 8'hA3);
      chk("t2_wl0", words_left, 0);
      chk("t2_done", evt_done, 1);
      chk("t2_rinc_off", rinc, 0);
      tick; #1;
      chk("t2_done_clear", evt_done, 0);
      chk("t2_ov_clear", out_valid, 0);
      chk("t2_rinc_count", c_rinc - s_rinc, 3);

      // Two-word burst with a four-cycle empty gap
      snap;
      cmd_valid = 1'b1; cmd_len = 5'd2; rempty = 1'b0; rdata = 8'hB1;
      #1;
      chk("t3_accept_ready", cmd_ready, 1);
      tick; cmd_valid = 1'b0; #1;
      chk("t3_rinc_b1", rinc, 1);
      chk("t3_wl2", words_left, 2);
      tick; rempty = 1'b1; #1;
      chk("t3_d1", out_data, 8'hB1);
      chk("t3_wl1", words_left, 1);
      chk("t3_stall_1", evt_empty_stall, 1);
      chk("t3_rc_0", retry_cnt, 0);
      for (int i = 1; i <= 3; i++) begin
         tick; #1;
         chk("t3_stall", evt_empty_stall, 1);
         chk("t3_rc", retry_cnt, i);
      end
      tick; rempty = 1'b0; rdata = 8'hB2; #1;
      chk("t3_rc_4", retry_cnt, 4);
      chk("t3_no_stall", evt_empty_stall, 0);
      chk("t3_rinc_b2", rinc, 1);
      tick; rempty = 1'b1; #1;
      chk("t3_d2", out_data, 8'hB2);
      chk("t3_rc_clear", retry_cnt, 0);
      chk("t3_wl0", words_left, 0);
      chk("t3_done", evt_done, 1);
      tick; #1;
      chk("t3_stall_count", c_stall - s_stall, 4);
      chk("t3_no_timeout", c_to - s_to, 0);
      chk("t3_done_count", c_done - s_done, 1);

      // Timeout on a permanently empty FIFO
      snap;
      cmd_valid = 1'b1; cmd_len = 5'd1; rempty = 1'b1;
      #1;
      chk("t4_accept_ready", cmd_ready, 1);
      tick; cmd_valid = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         #1;
         chk("t4_stall", evt_empty_stall, 1);
         chk("t4_rc", retry_cnt, k - 1);
         chk("t4_timeout", evt_timeout, (k == 10));
         chk("t4_rinc", rinc, 0);
         tick;
      end
      #1;
      chk("t4_idle_ready", cmd_ready, 1);
      chk("t4_stall_off", evt_empty_stall, 0);
      chk("t4_timeout_off", evt_timeout, 0);
      chk("t4_no_done", evt_done, 0);
      tick; #1;
      chk("t4_stall_count", c_stall - s_stall, 10);
      chk("t4_timeout_count", c_to - s_to, 1);
      chk("t4_rinc_count", c_rinc - s_rinc, 0);
      chk("t4_done_count", c_done - s_done, 0);

      // Underflow injection
      snap;
      cmd_valid = 1'b1; cmd_err_inject = 1'b1; cmd_len = '0; rempty = 1'b1;
      #1;
      chk("t5_accept_ready", cmd_ready, 1);
      tick; cmd_valid = 1'b0; cmd_err_inject = 1'b0; #1;
      chk("t5_rinc", rinc, 1);
      chk("t5_uf", evt_underflow, 1);
      chk("t5_ov", out_valid, 0);
      chk("t5_no_done_yet", evt_done, 0);
      tick; #1;
      chk("t5_rinc_off", rinc, 0);
      chk("t5_uf_off", evt_underflow, 0);
      chk("t5_done", evt_done, 1);
      chk("t5_ov_still0", out_valid, 0);
      tick; #1;
      chk("t5_done_clear", evt_done, 0);
      chk("t5_rinc_count", c_rinc - s_rinc, 1);
      chk("t5_uf_count", c_uf - s_uf, 1);

      // Zero-length command completes without reading
      cmd_valid = 1'b1; cmd_len = '0;
      #1;
      chk("tz_accept_ready", cmd_ready, 1);
      tick; cmd_valid = 1'b0; #1;
      chk("tz_done", evt_done, 1);
      chk("tz_ready", cmd_ready, 1);
      chk("tz_rinc", rinc, 0);
      chk("tz_wl", words_left, 0);

      // Backpressure then soft reset with a competing command
      tick;
      cmd_valid = 1'b1; cmd_len = 5'd4; out_ready = 1'b0; rempty = 1'b0; rdata = 8'hC1;
      #1;
      chk("t6_accept_ready", cmd_ready, 1);
      tick; cmd_valid = 1'b0; #1;
      chk("t6_rinc", rinc, 1);
      chk("t6_wl4", words_left, 4);
      tick; rdata = 8'hC2; #1;
      chk("t6_ov", out_valid, 1);
      chk("t6_d1", out_data, 8'hC1);
      chk("t6_wl3", words_left, 3);
      chk("t6_bp_rinc", rinc, 0);
      chk("t6_bp_rc", retry_cnt, 0);
      tick; #1;
      chk("t6_bp_rinc2", rinc, 0);
      chk("t6_bp_rc2", retry_cnt, 0);
      chk("t6_bp_stall", evt_empty_stall, 0);
      chk("t6_bp_d", out_data, 8'hC1);
      tick; soft_rst_req = 1'b1; cmd_valid = 1'b1; cmd_len = 5'd2; snap; #1;
      chk("t6_soft_ready", cmd_ready, 0);
      chk("t6_soft_rinc", rinc, 0);
      tick; soft_rst_req = 1'b0; #1;
      chk("t6_soft_ov", out_valid, 0);
      chk("t6_soft_fifo", fifo_rrst_n, 0);
      chk("t6_soft_wl", words_left, 0);
      chk("t6_soft_ready2", cmd_ready, 0);
      for (int i = 0; i < 3; i++) begin
         tick; #1;
         chk("t6_hold_low", fifo_rrst_n, 0);
         chk("t6_hold_ready", cmd_ready, 0);
      end
      tick; #1;
      chk("t6_release", fifo_rrst_n, 1);
      chk("t6_rst_done", evt_rst_done, 1);
      chk("t6_rd_ready", cmd_ready, 0);
      chk("t6_not_accepted", words_left, 0);
      tick; #1;
      chk("t6_rst_done_clear", evt_rst_done, 0);
      chk("t6_ready_after", cmd_ready, 1);
      chk("t6_still_not_accepted", words_left, 0);
      tick; cmd_valid = 1'b0; out_ready = 1'b1; #1;
      chk("t6_accepted_wl", words_left, 2);
      chk("t6_new_rinc", rinc, 1);
      chk("t6_rstd_count", c_rstd - s_rstd, 1);
      tick; rrst_n = 1'b0; #1;
      chk("t6_cap_c2", out_data, 8'hC2);
      chk("t6_cap_wl", words_left, 1);
      tick; rrst_n = 1'b1; #1;
      chk("t7_rst_ov", out_valid, 0);
      chk("t7_rst_data", out_data, 0);
      chk("t7_rst_wl", words_left, 0);
      chk("t7_rst_fifo", fifo_rrst_n, 0);
      chk("t7_rst_rinc", rinc, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/afifo_rd_master.md
Name: afifo_rd_master

Overview:
Synthesizable read-side traffic engine for the async FIFO, running entirely in the read clock domain. It accepts read commands (burst of N words, or an injected underflow) and drives the FIFO read port (rinc/rdata/rempty). It retries on empty with a bounded budget and forwards captured words on a valid/ready stream. It reports stall, timeout, underflow, done and reset-done events, and sequences the FIFO read-domain reset.

Parameters:
DATA_WIDTH, 8, FIFO data width (matches afifo_tb_pkg::DATA_WIDTH)
ADDR_WIDTH, 4, FIFO address width (matches afifo_tb_pkg::ADDR_WIDTH)
MAX_EMPTY_RETRY, 10, consecutive empty cycles per word before timeout
RST_CYCLES, 4, cycles fifo_rrst_n is held low by a reset sequence
CNT_WIDTH, ADDR_WIDTH+1, width of burst length / words_left

Ports:
rclk  in  1  read-domain clock
rrst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accept
cmd_len  in  CNT_WIDTH  words to read (0 = no-op)
cmd_err_inject  in  1  command is an underflow injection
soft_rst_req  in  1  request FIFO read-side reset sequence
fifo_rrst_n  out  1  reset to FIFO read domain
rinc  out  1  FIFO read increment
rdata  in  DATA_WIDTH  FIFO read data (valid while rempty=0)
rempty  in  1  FIFO empty flag
out_valid  out  1  captured word valid
out_ready  in  1  downstream accept
out_data  out  DATA_WIDTH  captured word
words_left  out  CNT_WIDTH  remaining words in current burst
retry_cnt  out  $clog2(MAX_EMPTY_RETRY+1)  consecutive empty cycles, current word
evt_empty_stall, evt_timeout, evt_underflow, evt_done, evt_rst_done  out  1 each  single-cycle event pulses

Behaviour:
- States: RST_HOLD, IDLE, READ, UNDERFLOW.
- rrst_n=0 (any cycle, any state): on that edge state=RST_HOLD with hold counter=0; fifo_rrst_n=0; rinc=0; cmd_ready=0; out_valid=0; out_data=0; words_left=0; retry_cnt=0; all evt_*=0. In-flight data is dropped.
- RST_HOLD: fifo_rrst_n=0 for RST_CYCLES cycles after reset release. Then fifo_rrst_n=1, evt_rst_done pulses for 1 cycle, next state is IDLE.
- IDLE: cmd_ready=1 unless soft_rst_req=1. A command is accepted on cmd_valid&cmd_ready.
  - cmd_err_inject=1 -> UNDERFLOW.
  - cmd_len=0 -> evt_done next cycle, stay IDLE.
  - Otherwise words_left<=cmd_len, retry_cnt<=0, next state READ.
- READ, evaluated each cycle; slot_free = !out_valid | out_ready:
  - rempty=0 & slot_free: rinc=1 (combinational from state/rempty/slot_free). On that edge out_data<=rdata, out_valid<=1, words_left--, retry_cnt<=0. If words_left was 1: evt_done pulses next cycle, next state IDLE.
  - rempty=1: rinc=0, evt_empty_stall pulses this cycle, retry_cnt++. When the MAX_EMPTY_RETRY-th consecutive empty cycle is observed, evt_timeout pulses in that same cycle, the remaining words are abandoned, and the next state is IDLE with no evt_done.
  - rempty=0 & !slot_free (backpressure): rinc=0; the cycle is neither a stall nor a retry.
- out_valid clears on out_ready when no new capture occurs in the same cycle.
- UNDERFLOW: rinc=1 for exactly one cycle regardless of rempty; evt_underflow pulses in the same cycle. No capture. Next state IDLE, then evt_done one cycle later.
- soft_rst_req=1 in any non-RST_HOLD state: abort the command, clear out_valid, words_left and retry_cnt, rinc=0, enter RST_HOLD. The sequence is identical to the post-reset one.
- soft_rst_req has priority over command acceptance in the same cycle; the command is not accepted.
- Only one command is outstanding at a time. words_left never wraps: a decrement happens only when it is nonzero.

Decomposition:
- Shared package (afifo_tb_pkg, or a new afifo_rd_pkg importing it) holds:
  - DATA_WIDTH, ADDR_WIDTH, MAX_EMPTY_RETRY, RST_CYCLES constants
  - rd_state_t enum {RST_HOLD, IDLE, READ, UNDERFLOW}
- One sub-module, afifo_rd_out_reg: the out_valid/out_data holding register with load/ready handshake and slot_free output.

Test Plan:
1. rrst_n low 3 cycles then high -> fifo_rrst_n stays 0 for 4 further cycles, then 1. evt_rst_done pulses once. cmd_ready=1 in the following cycle.
2. FIFO preloaded 0xA1,0xA2,0xA3; cmd_len=3; out_ready=1 -> rinc high 3 consecutive cycles; out_data 0xA1,0xA2,0xA3 on consecutive cycles. words_left goes 3->0. evt_done pulses 1 cycle after the last capture.
3. cmd_len=2; one word present, then rempty=1 for 4 cycles, then a second word -> 4 evt_empty_stall pulses. retry_cnt reaches 4, then returns to 0. Both words delivered, evt_done, no evt_timeout.
4. cmd_len=1, rempty held 1 -> 10 evt_empty_stall pulses, with evt_timeout coinciding with the 10th. rinc never asserted, return to IDLE, no evt_done.
5. rempty=1, cmd_err_inject=1 -> rinc=1 for exactly 1 cycle with evt_underflow in the same cycle. out_valid stays 0. evt_done follows 1 cycle later.
6. cmd_len=4, out_ready=0, data available -> exactly one word captured; rinc stays 0 after that and retry_cnt stays 0. soft_rst_req asserted mid-burst (with cmd_valid also high) -> out_valid clears and fifo_rrst_n is low for 4 cycles. The new command is not accepted until after evt_rst_done.
